// File: rtl/tile_clip_pkg.sv
`default_nettype none
// ============================================================================
//  tile_clip_pkg : shared state type, widths and coordinate type for the
//                  tile clip sequencer
//  Revision     : 1.0
// ============================================================================
package tile_clip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_TILE_W  = 32;
    localparam int DEF_TILE_H  = 32;
    localparam int DEF_COORD_W = 12;

    localparam int LEN_W  = $clog2(DEF_TILE_W + 1);
    localparam int LINE_W = $clog2(DEF_TILE_H);
    localparam int COL_W  = $clog2(DEF_TILE_W);
    localparam int HGT_W  = $clog2(DEF_TILE_H + 1);

    // Two guard bits so origin + tile size never overflows
    localparam int CX_W = DEF_COORD_W + 2;
    typedef logic signed [CX_W-1:0] coord_t;

endpackage
`default_nettype wire

// File: rtl/axis_clip.sv
`default_nettype none
// ============================================================================
//  axis_clip : clips one axis of a tile window against the image extent
//  Revision  : 1.0
// ============================================================================
module axis_clip
    import tile_clip_pkg::*;
#(
    parameter int TILE   = 32,
    parameter int IM_DIM = 640,
    parameter int SIZE_W = 6
) (
    input  coord_t            c,
    output coord_t            lo,
    output logic [SIZE_W-1:0] size,
    output logic [SIZE_W-1:0] off
);

    localparam coord_t TILE_S = coord_t'(TILE);
    localparam coord_t IM_S   = coord_t'(IM_DIM);

    coord_t hi_raw;
    coord_t hi;

    always_comb begin
        lo     = c[CX_W-1] ? '0 : c;
        hi_raw = c + TILE_S;
        hi     = (hi_raw < IM_S) ? hi_raw : IM_S;
        size   = (hi > lo) ? SIZE_W'(hi - lo) : '0;
        off    = SIZE_W'(lo - c);
    end

endmodule
`default_nettype wire

// File: rtl/tile_clip_sequencer.sv
`default_nettype none
// ============================================================================
//  tile_clip_sequencer : clips a tile window against the image and issues one
//                        row-fetch request per visible tile row
//  Revision            : 1.0
// ============================================================================
module tile_clip_sequencer
    import tile_clip_pkg::*;
#(
    parameter int IM_WIDTH  = 640,
    parameter int IM_HEIGHT = 480,
    parameter int TILE_W    = DEF_TILE_W,
    parameter int TILE_H    = DEF_TILE_H,
    parameter int COORD_W   = DEF_COORD_W,
    parameter int ADDR_W    = 32
) (
    input  logic                      p_clk,
    input  logic                      preset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic signed [COORD_W-1:0] req_x,
    input  logic signed [COORD_W-1:0] req_y,
    input  logic [ADDR_W-1:0]         im_base,
    input  logic                      abort,
    output logic                      row_valid,
    input  logic                      row_ready,
    output logic [ADDR_W-1:0]         row_addr,
    output logic [LEN_W-1:0]          row_len,
    output logic [LINE_W-1:0]         row_dst_line,
    output logic [COL_W-1:0]          row_dst_col,
    output logic [LEN_W-1:0]          win_w,
    output logic [HGT_W-1:0]          win_h,
    output logic [LEN_W-1:0]          off_x,
    output logic [HGT_W-1:0]          off_y,
    output logic                      empty,
    output logic                      busy,
    output logic                      done
);

    state_t              state;
    state_t              state_nxt;
    coord_t              x_q;
    coord_t              y_q;
    logic [ADDR_W-1:0]   base_q;
    logic [LINE_W-1:0]   row_cnt;

    coord_t              lo_x;
    coord_t              lo_y;
    logic [LEN_W-1:0]    size_x;
    logic [LEN_W-1:0]    offs_x;
    logic [HGT_W-1:0]    size_y;
    logic [HGT_W-1:0]    offs_y;

    logic                accept;
    logic                row_hs;
    logic                last_row;
    logic                calc_empty;

    axis_clip #(.TILE(TILE_W), .IM_DIM(IM_WIDTH), .SIZE_W(LEN_W)) u_clip_x (
        .c    (x_q),
        .lo   (lo_x),
        .size (size_x),
        .off  (offs_x)
    );

    axis_clip #(.TILE(TILE_H), .IM_DIM(IM_HEIGHT), .SIZE_W(HGT_W)) u_clip_y (
        .c    (y_q),
        .lo   (lo_y),
        .size (size_y),
        .off  (offs_y)
    );

    assign accept       = req_valid & req_ready;
    assign row_hs       = row_valid & row_ready;
    assign last_row     = (HGT_W'(row_cnt) + HGT_W'(1)) == win_h;
    assign calc_empty   = (size_x == '0) || (size_y == '0);
    assign row_len      = win_w;
    assign row_dst_col  = off_x[COL_W-1:0];
    assign row_dst_line = off_y[LINE_W-1:0] + row_cnt;

    always_ff @(posedge p_clk or negedge preset_n) begin
        if (!preset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        // req_ready is held low while reset is asserted
        req_ready = (state == IDLE) && preset_n;
        row_valid = (state == ISSUE);
        done      = (state == DONE);
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    state_nxt = calc_empty ? DONE : ISSUE;
            ISSUE:   if (row_hs && last_row) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && (state != IDLE)) state_nxt = IDLE;
    end

    always_ff @(posedge p_clk or negedge preset_n) begin
        if (!preset_n) begin
            x_q      <= '0;
            y_q      <= '0;
            base_q   <= '0;
            row_cnt  <= '0;
            row_addr <= '0;
            win_w    <= '0;
            win_h    <= '0;
            off_x    <= '0;
            off_y    <= '0;
            empty    <= 1'b0;
        end else begin
            if (accept) begin
                x_q    <= coord_t'(req_x);
                y_q    <= coord_t'(req_y);
                base_q <= im_base;
            end
            if (state == CALC) begin
                row_cnt  <= '0;
                row_addr <= base_q + ADDR_W'(lo_y) * ADDR_W'(IM_WIDTH) + ADDR_W'(lo_x);
                off_x    <= offs_x;
                off_y    <= offs_y;
                empty    <= calc_empty;
                win_w    <= calc_empty ? '0 : size_x;
                win_h    <= calc_empty ? '0 : size_y;
            end
            // A row accepted together with abort still counts as consumed
            if (row_hs) begin
                row_cnt  <= row_cnt + LINE_W'(1);
                row_addr <= row_addr + ADDR_W'(IM_WIDTH);
            end
        end
    end

endmodule
`default_nettype wire
